cpu_cmd_driver: RTL

Command initiator that drives the `CPU` block's load/execute strobe interface on behalf of a host. It accepts one command at a time over a valid/ready handshake and issues the single-cycle `ce` strobe with the matching `load`/`opcode`/`data_in`/`cin`/`cout` values. For ALU operations it waits out the CPU's execute latency, then captures `data_out` and returns it over a second valid/ready handshake. It sits between the host/testbench sequencer and `CPU`, with its `cpu_*` outputs wired directly to the same-named `CPU` inputs.

---
 rtl/cpu_cmd_driver_if.sv | 24 ++
 rtl/cpu_cmd_driver.sv | 80 ++++++++
 2 files changed

// File: rtl/cpu_cmd_driver_if.sv
// cpu_cmd_driver_if: host-side command and result handshakes of cpu_cmd_driver
// Ports: cmd_valid/cmd_ready with cmd_load, cmd_reg, cmd_op, cmd_data, cmd_cin, cmd_cout;
//        res_valid/res_ready with res_data. master = host, slave = driver.
interface cpu_cmd_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_reg;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_cin;
    logic       cmd_cout;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    modport master (
        output cmd_valid, cmd_load, cmd_reg, cmd_op, cmd_data, cmd_cin, cmd_cout, res_ready,
        input  cmd_ready, res_valid, res_data
    );
    modport slave (
        input  cmd_valid, cmd_load, cmd_reg, cmd_op, cmd_data, cmd_cin, cmd_cout, res_ready,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/cpu_cmd_driver.sv
// cpu_cmd_driver: issues one host command at a time on the CPU strobe interface and returns ALU results
// Ports: clk, rst (async active-high); host (slave modport): command and result handshakes;
//        busy (state not IDLE), cmd_count (accepted commands, wraps);
//        cpu_ce/cpu_load/cpu_cin/cpu_cout/cpu_opcode/cpu_data_in: registered CPU strobe and fields;
//        cpu_data_out: CPU accumulator, sampled OP_LATENCY cycles after the strobe leaves.
module cpu_cmd_driver #(
    parameter int OP_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    cpu_cmd_driver_if.slave     host,
    output logic                busy,
    output logic [15:0]         cmd_count,
    output logic                cpu_ce,
    output logic                cpu_load,
    output logic                cpu_cin,
    output logic                cpu_cout,
    output logic [6:0]          cpu_opcode,
    output logic [7:0]          cpu_data_in,
    input  logic [7:0]          cpu_data_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CW = $clog2(OP_LATENCY);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic accept;
    assign accept         = host.cmd_valid && state_q == IDLE;
    assign host.cmd_ready = state_q == IDLE;
    assign busy           = state_q != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // cpu_load is only nonzero during ISSUE, so it doubles as the captured command type there
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = cpu_load ? IDLE : WAIT;
            WAIT:    state_d = cnt_q == '0 ? RESP : WAIT;
            RESP:    state_d = host.res_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // The cpu_* flops are the capture registers, so the strobe and fields are glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ce        <= 1'b0;
            cpu_load      <= 1'b0;
            cpu_cin       <= 1'b0;
            cpu_cout      <= 1'b0;
            cpu_opcode    <= '0;
            cpu_data_in   <= '0;
            cmd_count     <= '0;
            cnt_q         <= '0;
            host.res_valid <= 1'b0;
            host.res_data  <= '0;
        end else begin
            cpu_ce   <= accept;
            cpu_load <= accept ? host.cmd_load : 1'b0;
            if (accept) begin
                cpu_opcode  <= {host.cmd_reg, host.cmd_op};
                cpu_data_in <= host.cmd_data;
                cpu_cin     <= host.cmd_cin;
                cpu_cout    <= host.cmd_cout;
                cmd_count   <= cmd_count + 16'd1;
            end
            if (state_q == ISSUE)
                cnt_q <= CW'(OP_LATENCY - 1);
            else if (state_q == WAIT && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            if (state_q == WAIT && cnt_q == '0) begin
                host.res_data  <= cpu_data_out;
                host.res_valid <= 1'b1;
            end else if (state_q == RESP && host.res_ready) begin
                host.res_valid <= 1'b0;
            end
        end
    end
endmodule
